multiply_2: RTL and testbench



---
 rtl/multiply_2.sv | 53 +++++
 tb/tb_multiply_2.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/multiply_2.sv
// multiply_2: sequential byte-lane elementwise multiplier, one word of 4 lane products per clock
// Ports: clk, rst (sync, active-high); start (level request, sampled in IDLE);
//        mat_A/mat_B operand banks in; mat_C registered result bank out; done registered completion flag.
module multiply_2 #(
  parameter int WORDS  = 256,
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LANES-1:0][LANE_W-1:0]   mat_A [WORDS],
  input  logic [LANES-1:0][LANE_W-1:0]   mat_B [WORDS],
  output logic [LANES-1:0][LANE_W-1:0]   mat_C [WORDS],
  output logic                           done
);
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx;
  logic w_last;
  logic [2*LANE_W-1:0] w_full [LANES];
  logic [LANES-1:0][LANE_W-1:0] w_prod;
  assign w_last = r_idx == IW'(WORDS-1);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_full[l] = (2*LANE_W)'(mat_A[r_idx][l]) * (2*LANE_W)'(mat_B[r_idx][l]);
    assign w_prod[l] = w_full[l][LANE_W-1:0];
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (start ? RUN : IDLE) :
             r_state == RUN  ? (w_last ? DONE : RUN) :
                               (start ? DONE : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx   <= r_state == RUN ? r_idx + 1'b1 : '0;
      done    <= w_next == DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WORDS; w++) mat_C[w] <= '0;
    end else if (r_state == RUN) begin
      mat_C[r_idx] <= w_prod;
    end
  end
endmodule

// File: tb/tb_multiply_2.sv
// tb_multiply_2: randomized self-checking bench for multiply_2 against a lane-arithmetic reference model
module tb_multiply_2;
  localparam int WORDS = 256;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0][7:0] mat_A [WORDS];
  logic [3:0][7:0] mat_B [WORDS];
  logic [3:0][7:0] mat_C [WORDS];
  logic done;
  logic [31:0] exp_c [WORDS];
  int n_vec = 0;
  int n_err = 0;

  multiply_2 dut (
    .clk(clk), .rst(rst), .start(start),
    .mat_A(mat_A), .mat_B(mat_B), .mat_C(mat_C), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] ref_word(input int w);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = 8'((int'(mat_A[w][l]) * int'(mat_B[w][l])) % 256);
    return r;
  endfunction

  task automatic rand_ops();
    for (int w = 0; w < WORDS; w++) begin
      mat_A[w] = $urandom;
      mat_B[w] = $urandom;
    end
  endtask

  task automatic check_all(input string tag);
    for (int w = 0; w < WORDS; w++) check($sformatf("%s C[%0d]", tag, w), mat_C[w], exp_c[w]);
  endtask

  task automatic clear_exp();
    for (int w = 0; w < WORDS; w++) exp_c[w] = '0;
  endtask

  // abort_at > 0 asserts rst on that RUN edge instead of finishing the run
  task automatic run(input string tag, input int abort_at);
    start = 1'b1;
    tick();
    for (int j = 1; j <= WORDS; j++) begin
      if (j == abort_at) begin
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        clear_exp();
        check({tag, " abort done"}, 32'(done), 32'd0);
        check_all({tag, " abort"});
        tick();
        check({tag, " idle done"}, 32'(done), 32'd0);
        return;
      end
      tick();
      exp_c[j-1] = ref_word(j-1);
      check($sformatf("%s step C[%0d]", tag, j-1), mat_C[j-1], exp_c[j-1]);
      if (j < WORDS) check($sformatf("%s pend C[%0d]", tag, j), mat_C[j], exp_c[j]);
      check($sformatf("%s done@%0d", tag, j), 32'(done), 32'(j == WORDS));
    end
    for (int h = 0; h < 3; h++) begin
      rand_ops();
      tick();
      check($sformatf("%s hold done %0d", tag, h), 32'(done), 32'd1);
    end
    check_all({tag, " hold"});
    start = 1'b0;
    tick();
    check({tag, " drop done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rand_ops();
    start = 1'($urandom);
    @(negedge clk);
    tick();
    rst = 1'b0;
    start = 1'b0;
    clear_exp();
    check("reset done", 32'(done), 32'd0);
    check_all("reset");
    for (int c = 0; c < 300; c++) begin
      if (c % 50 == 0) rand_ops();
      tick();
    end
    check("idle done", 32'(done), 32'd0);
    check_all("idle");

    for (int w = 0; w < WORDS; w++) begin
      mat_A[w] = w == 0 ? 32'h02020202 : '0;
      mat_B[w] = w == 0 ? 32'h04040404 : '0;
    end
    run("basic", 0);
    check("basic C0", mat_C[0], 32'h08080808);
    check_all("basic");

    for (int w = 0; w < WORDS; w++) begin
      mat_A[w] = 32'hFFFFFFFF;
      mat_B[w] = 32'hFFFFFFFF;
    end
    run("full", 0);
    check("full C77", mat_C[77], 32'h01010101);

    for (int w = 0; w < WORDS; w++) begin
      mat_A[w] = {8'($urandom), 8'd255, 8'd15, 8'd16};
      mat_B[w] = {8'($urandom), 8'd255, 8'd17, 8'd16};
    end
    run("edge", 0);
    check("edge 16x16", 32'(mat_C[5][0]), 32'h00);
    check("edge 15x17", 32'(mat_C[5][1]), 32'hFF);
    check("edge 255x255", 32'(mat_C[5][2]), 32'h01);

    for (int w = 0; w < WORDS; w++)
      for (int l = 0; l < 4; l++) begin
        mat_A[w][l] = 8'(w);
        mat_B[w][l] = 8'(l + 1);
      end
    run("index", 0);
    check("index C255L3", 32'(mat_C[255][3]), 32'hFC);

    rand_ops();
    run("rand1", 0);
    rand_ops();
    run("abort", 101);
    rand_ops();
    run("clean", 0);
    check_all("clean");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
